// File: rtl/pipelined_multi_add_pkg.sv
// Shared constant helpers for the pipelined multi-operand adder: operand-tree
// depth, per-level group counts and the derived output width.
package pipelined_multi_add_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    // Number of 3:1 levels needed to reduce n operands to one.
    function automatic int num_stg3(input int n);
        int s;
        int m;
        s = 0;
        m = 1;
        while (m < n) begin
            m = m * 3;
            s++;
        end
        return s;
    endfunction

    function automatic int lvl_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 2) / 3;
        end
        return c;
    endfunction

    function automatic int calc_out_w(input int width, input int num_in,
                                      input int accum, input int acc_extra);
        return width + clog2(num_in) + ((accum != 0) ? acc_extra : 0);
    endfunction

endpackage

// File: rtl/pipelined_multi_add_stage.sv
// One registered 3:1 reduction level. Operands arrive already widened to their
// final width, so each group sum is exact without further growth.
module ternary_add_stage
    import pipelined_multi_add_pkg::*;
#(
    parameter int WIDTH_IN = 8,
    parameter int N_IN     = 3,
    parameter int SIGN_EXT = 0,
    localparam int N_OUT   = lvl_count(N_IN, 1)
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      en,
    input  logic                      vi,
    input  logic [N_IN*WIDTH_IN-1:0]  d,
    output logic                      vo,
    output logic [N_OUT*WIDTH_IN-1:0] q
);

    localparam int W = WIDTH_IN;

    logic [3*N_OUT*W-1:0] padded;
    logic [N_OUT*W-1:0]   sum;

    always_comb begin
        padded              = '0;
        padded[N_IN*W-1:0]  = d;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_grp
        if (SIGN_EXT != 0) begin : g_signed
            assign sum[g*W +: W] = $signed(padded[(3*g)*W +: W])
                                 + $signed(padded[(3*g+1)*W +: W])
                                 + $signed(padded[(3*g+2)*W +: W]);
        end else begin : g_unsigned
            assign sum[g*W +: W] = padded[(3*g)*W +: W]
                                 + padded[(3*g+1)*W +: W]
                                 + padded[(3*g+2)*W +: W];
        end
    end

    // A bubble clears the valid bit but leaves the data register untouched.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vo <= 1'b0;
            q  <= '0;
        end else if (en) begin
            vo <= vi;
            if (vi) begin
                q <= sum;
            end
        end
    end

endmodule

// File: rtl/pipelined_multi_add.sv
// Pipelined NUM_IN-operand adder built from registered 3:1 levels, with
// ready/valid flow control and an optional running-total accumulator.
module pipelined_multi_add
    import pipelined_multi_add_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 9,
    parameter int SIGN_EXT  = 0,
    parameter int ACCUM     = 0,
    parameter int ACC_EXTRA = 8,
    localparam int OUT_W    = calc_out_w(WIDTH, NUM_IN, ACCUM, ACC_EXTRA)
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_sum
);

    localparam int NUM_STG = num_stg3(NUM_IN);

    logic                    adv;
    logic [NUM_IN*OUT_W-1:0] ext_data;
    logic [OUT_W-1:0]        last_sum;
    logic                    last_vo;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
        if (SIGN_EXT != 0) begin : g_sx
            assign ext_data[k*OUT_W +: OUT_W] =
                {{(OUT_W-WIDTH){in_data[k*WIDTH+WIDTH-1]}}, in_data[k*WIDTH +: WIDTH]};
        end else begin : g_zx
            assign ext_data[k*OUT_W +: OUT_W] =
                {{(OUT_W-WIDTH){1'b0}}, in_data[k*WIDTH +: WIDTH]};
        end
    end

    // Each level feeds the next; all levels share one advance enable.
    for (genvar i = 0; i < NUM_STG; i++) begin : g_stg
        localparam int NI = lvl_count(NUM_IN, i);
        localparam int NO = lvl_count(NUM_IN, i + 1);

        logic [NI*OUT_W-1:0] d;
        logic                vi;
        logic [NO*OUT_W-1:0] q;
        logic                vo;

        if (i == 0) begin : g_first
            assign d  = ext_data;
            assign vi = in_valid;
        end else begin : g_next
            assign d  = g_stg[i-1].q;
            assign vi = g_stg[i-1].vo;
        end

        ternary_add_stage #(
            .WIDTH_IN (OUT_W),
            .N_IN     (NI),
            .SIGN_EXT (SIGN_EXT)
        ) u_stage (
            .clk    (clk),
            .arst_n (arst_n),
            .en     (adv),
            .vi     (vi),
            .d      (d),
            .vo     (vo),
            .q      (q)
        );
    end

    assign last_sum = g_stg[NUM_STG-1].q;
    assign last_vo  = g_stg[NUM_STG-1].vo;

    if (ACCUM != 0) begin : g_acc
        logic [NUM_STG-1:0] clr_pipe;
        logic               acc_valid;
        logic [OUT_W-1:0]   acc;

        // The clear flag rides alongside its sample so it meets the total on time.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                clr_pipe  <= '0;
                acc_valid <= 1'b0;
                acc       <= '0;
            end else if (adv) begin
                clr_pipe[0] <= acc_clr;
                for (int s = 1; s < NUM_STG; s++) begin
                    clr_pipe[s] <= clr_pipe[s-1];
                end
                acc_valid <= last_vo;
                if (last_vo) begin
                    acc <= clr_pipe[NUM_STG-1] ? last_sum : acc + last_sum;
                end
            end
        end

        assign out_valid = acc_valid;
        assign out_sum   = acc;
    end else begin : g_noacc
        logic unused_clr;
        assign unused_clr = acc_clr;
        assign out_valid  = last_vo;
        assign out_sum    = last_sum;
    end

endmodule
